// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Optional result flags (rsp_zero, rsp_neg) are built when ALU_RR_ARBITER_FLAGS_EN is defined.
//
// state | meaning
// IDLE  | no op in flight; request handshake is open
// EXEC  | operands driven to the ALU, result settles this cycle
// RESP  | result held for the owner until its rsp_ready
module alu_rr_arbiter #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [OP_W-1:0]   req_op_0,
    output logic              rsp_valid_0,
    input  logic              rsp_ready_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [OP_W-1:0]   req_op_1,
    output logic              rsp_valid_1,
    input  logic              rsp_ready_1,
    output logic [DATA_W-1:0] rsp_data,
    output logic [DATA_W-1:0] alu_opperand_1,
    output logic [DATA_W-1:0] alu_opperand_2,
    output logic [OP_W-1:0]   alu_opcode,
    input  logic [DATA_W-1:0] alu_out,
`ifdef ALU_RR_ARBITER_FLAGS_EN
    output logic              rsp_zero,
    output logic              rsp_neg,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    logic   last_grant;
    logic   owner;
    logic   grant_0;
    logic   grant_1;
    logic   rsp_ready_owner;

    // Under contention the port that did not win last time is served.
    always_comb begin
        grant_0 = 1'b0;
        grant_1 = 1'b0;
        if (state == IDLE && rst_n) begin
            if (req_valid_0 && req_valid_1) begin
                grant_0 = last_grant;
                grant_1 = !last_grant;
            end else begin
                grant_0 = req_valid_0;
                grant_1 = req_valid_1;
            end
        end
    end

    assign req_ready_0     = grant_0;
    assign req_ready_1     = grant_1;
    assign rsp_ready_owner = owner ? rsp_ready_1 : rsp_ready_0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            alu_opperand_1 <= '0;
            alu_opperand_2 <= '0;
            alu_opcode     <= '0;
            rsp_data       <= '0;
            rsp_valid_0    <= 1'b0;
            rsp_valid_1    <= 1'b0;
            busy           <= 1'b0;
`ifdef ALU_RR_ARBITER_FLAGS_EN
            rsp_zero       <= 1'b0;
            rsp_neg        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_0 || grant_1) begin
                        alu_opperand_1 <= grant_1 ? req_a_1  : req_a_0;
                        alu_opperand_2 <= grant_1 ? req_b_1  : req_b_0;
                        alu_opcode     <= grant_1 ? req_op_1 : req_op_0;
                        owner          <= grant_1;
                        last_grant     <= grant_1;
                        busy           <= 1'b1;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data    <= alu_out;
                    rsp_valid_0 <= !owner;
                    rsp_valid_1 <= owner;
`ifdef ALU_RR_ARBITER_FLAGS_EN
                    rsp_zero    <= (alu_out == '0);
                    rsp_neg     <= alu_out[DATA_W-1];
`endif
                    state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready_owner) begin
                        rsp_valid_0 <= 1'b0;
                        rsp_valid_1 <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: table vectors, hand sequences and a
// randomized run against a transaction-level model of the arbitration rules.
module tb_alu_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid_0 = 1'b0, req_valid_1 = 1'b0;
    logic       req_ready_0, req_ready_1;
    logic [7:0] req_a_0 = '0, req_b_0 = '0, req_a_1 = '0, req_b_1 = '0;
    logic [2:0] req_op_0 = '0, req_op_1 = '0;
    logic       rsp_valid_0, rsp_valid_1;
    logic       rsp_ready_0 = 1'b0, rsp_ready_1 = 1'b0;
    logic [7:0] rsp_data, alu_opperand_1, alu_opperand_2, alu_out;
    logic [2:0] alu_opcode;
    logic       busy;
`ifdef ALU_RR_ARBITER_FLAGS_EN
    logic       rsp_zero, rsp_neg;
`endif

    always #5 clk = ~clk;

    alu_rr_arbiter #(.DATA_W(8), .OP_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_ready_0(req_ready_0),
        .req_a_0(req_a_0), .req_b_0(req_b_0), .req_op_0(req_op_0),
        .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0),
        .req_valid_1(req_valid_1), .req_ready_1(req_ready_1),
        .req_a_1(req_a_1), .req_b_1(req_b_1), .req_op_1(req_op_1),
        .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1),
        .rsp_data(rsp_data),
        .alu_opperand_1(alu_opperand_1), .alu_opperand_2(alu_opperand_2),
        .alu_opcode(alu_opcode), .alu_out(alu_out),
`ifdef ALU_RR_ARBITER_FLAGS_EN
        .rsp_zero(rsp_zero), .rsp_neg(rsp_neg),
`endif
        .busy(busy)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
        case (op)
            3'd1:    return a + b;
            3'd2:    return a - b;
            3'd3:    return a & b;
            3'd4:    return a | b;
            3'd5:    return ~a;
            3'd6:    return ~b;
            default: return 8'h00;
        endcase
    endfunction

    // The external ALU the arbiter drives.
    always_comb alu_out = alu_ref(alu_opperand_1, alu_opperand_2, alu_opcode);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one op outstanding, result visible one cycle after accept.
    bit         m_pend;
    int         m_owner;
    int         m_last;
    int         m_age;
    logic [7:0] m_a, m_b, m_data;
    logic [2:0] m_op;
    int         acc_port;
    int         dut_hs_port;
    logic [7:0] dut_hs_data;
    logic [1:0] dut_hs_flags;

    task automatic model_reset();
        m_pend = 0; m_last = 1; m_owner = 0; m_age = 0;
        m_a = '0; m_b = '0; m_op = '0; m_data = '0;
        acc_port = -1; dut_hs_port = -1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, {req_ready_1, req_ready_0}, 2'b00);
        chk({tag, "_rsp_valid"}, {rsp_valid_1, rsp_valid_0}, 2'b00);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_rsp_data"}, rsp_data, 8'h00);
        chk({tag, "_alu_in"}, {alu_opperand_1, alu_opperand_2, alu_opcode}, 19'h0);
`ifdef ALU_RR_ARBITER_FLAGS_EN
        chk({tag, "_flags"}, {rsp_zero, rsp_neg}, 2'b00);
`endif
    endtask

    // Called at posedge+1 with inputs applied; compares, advances the model, moves one cycle.
    task automatic cycle_check();
        int  g;
        bit  rdy_owner;
        #1;
        g = -1;
        if (!m_pend) begin
            if (req_valid_0 && req_valid_1) g = 1 - m_last;
            else if (req_valid_0) g = 0;
            else if (req_valid_1) g = 1;
        end
        chk("req_ready_0", req_ready_0, (g == 0));
        chk("req_ready_1", req_ready_1, (g == 1));
        chk("rsp_valid_0", rsp_valid_0, (m_pend && m_age >= 1 && m_owner == 0));
        chk("rsp_valid_1", rsp_valid_1, (m_pend && m_age >= 1 && m_owner == 1));
        chk("rsp_data", rsp_data, m_data);
        chk("busy", busy, m_pend);
        chk("alu_in", {alu_opperand_1, alu_opperand_2, alu_opcode}, {m_a, m_b, m_op});
`ifdef ALU_RR_ARBITER_FLAGS_EN
        chk("flags", {rsp_zero, rsp_neg}, {(m_data == 8'h00), m_data[7]});
        dut_hs_flags = {rsp_zero, rsp_neg};
`else
        dut_hs_flags = 2'b00;
`endif
        dut_hs_port = -1;
        if (rsp_valid_0 && rsp_ready_0) dut_hs_port = 0;
        else if (rsp_valid_1 && rsp_ready_1) dut_hs_port = 1;
        dut_hs_data = rsp_data;

        acc_port  = -1;
        rdy_owner = (m_owner == 1) ? rsp_ready_1 : rsp_ready_0;
        if (!m_pend) begin
            if (g >= 0) begin
                acc_port = g; m_pend = 1; m_owner = g; m_last = g; m_age = 0;
                m_a  = (g == 1) ? req_a_1  : req_a_0;
                m_b  = (g == 1) ? req_b_1  : req_b_0;
                m_op = (g == 1) ? req_op_1 : req_op_0;
            end
        end else if (m_age == 0) begin
            m_data = alu_ref(m_a, m_b, m_op);
            m_age  = 1;
        end else if (rdy_owner) begin
            m_pend = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input int p);
        bit ok = 0;
        for (int c = 0; c < 12; c++) begin
            cycle_check();
            if (acc_port == p) begin ok = 1; break; end
        end
        chk("accept_within_bound", ok, 1'b1);
    endtask

    task automatic wait_hs(input int p, output logic [7:0] d, output logic [1:0] f);
        bit ok = 0;
        d = 'x; f = 'x;
        for (int c = 0; c < 12; c++) begin
            cycle_check();
            if (dut_hs_port == p) begin ok = 1; d = dut_hs_data; f = dut_hs_flags; break; end
        end
        chk("response_within_bound", ok, 1'b1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic [1:0] flags;   // {zero, neg}
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic [1:0] f;
        int         grants[$];
        int         n0, n1;

        vecs[0]  = '{8'h12, 8'h34, 3'd1, 8'h46, 2'b00};
        vecs[1]  = '{8'hFF, 8'h01, 3'd1, 8'h00, 2'b10};
        vecs[2]  = '{8'h00, 8'h01, 3'd2, 8'hFF, 2'b01};
        vecs[3]  = '{8'hAA, 8'h55, 3'd7, 8'h00, 2'b10};
        vecs[4]  = '{8'hAA, 8'h55, 3'd0, 8'h00, 2'b10};
        vecs[5]  = '{8'hF0, 8'h0F, 3'd4, 8'hFF, 2'b01};
        vecs[6]  = '{8'h0F, 8'h00, 3'd5, 8'hF0, 2'b01};
        vecs[7]  = '{8'h00, 8'h3C, 3'd6, 8'hC3, 2'b01};
        vecs[8]  = '{8'hF0, 8'h3C, 3'd3, 8'h30, 2'b00};
        vecs[9]  = '{8'h05, 8'h07, 3'd2, 8'hFE, 2'b01};
        vecs[10] = '{8'hC3, 8'h3C, 3'd3, 8'h00, 2'b10};

        // Reset state, with both requesters already valid.
        model_reset();
        req_valid_0 = 1; req_valid_1 = 1;
        #12;
        check_reset_vals("reset");
        req_valid_0 = 0; req_valid_1 = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;

        // Table vectors on port 0; port 1 response must stay low throughout.
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        for (int i = 0; i < 11; i++) begin
            req_a_0 = vecs[i].a; req_b_0 = vecs[i].b; req_op_0 = vecs[i].op;
            req_valid_0 = 1;
            wait_accept(0);
            req_valid_0 = 0;
            wait_hs(0, d, f);
            chk($sformatf("vec%0d_result", i), d, vecs[i].res);
`ifdef ALU_RR_ARBITER_FLAGS_EN
            chk($sformatf("vec%0d_flags", i), f, vecs[i].flags);
`endif
        end

        // Field stability: operands change right after the accept edge.
        req_a_0 = 8'h10; req_b_0 = 8'h01; req_op_0 = 3'd1; req_valid_0 = 1;
        wait_accept(0);
        req_valid_0 = 0; req_a_0 = 8'h80; req_b_0 = 8'h7F; req_op_0 = 3'd3;
        wait_hs(0, d, f);
        chk("stability_result", d, 8'h11);

        // Response backpressure on port 1 with port 0 waiting.
        req_a_1 = 8'h0F; req_b_1 = 8'h99; req_op_1 = 3'd5; req_valid_1 = 1;
        rsp_ready_1 = 0; rsp_ready_0 = 1;
        wait_accept(1);
        req_valid_1 = 0;
        req_a_0 = 8'h01; req_b_0 = 8'h02; req_op_0 = 3'd1; req_valid_0 = 1;
        cycle_check();
        for (int c = 0; c < 5; c++) begin
            chk("bp_hold", {rsp_valid_1, rsp_data, req_ready_0}, {1'b1, 8'hF0, 1'b0});
            cycle_check();
        end
        rsp_ready_1 = 1;
        cycle_check();
        chk("bp_ready0_after_hs", {rsp_valid_1, req_ready_0}, 2'b01);
        wait_accept(0);
        req_valid_0 = 0;
        wait_hs(0, d, f);
        chk("bp_port0_result", d, 8'h03);

        // Asynchronous reset during EXEC discards the op.
        req_a_1 = 8'h21; req_b_1 = 8'h12; req_op_1 = 3'd1; req_valid_1 = 1;
        wait_accept(1);
        req_valid_1 = 0;
        #2 rst_n = 0;
        #1;
        check_reset_vals("midop_reset");
        model_reset();
        @(negedge clk) rst_n = 1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 4; c++) cycle_check();

        // Contention right after reset: grants alternate starting with port 0.
        req_a_0 = 8'h05; req_b_0 = 8'h07; req_op_0 = 3'd2;
        req_a_1 = 8'hF0; req_b_1 = 8'h3C; req_op_1 = 3'd3;
        req_valid_0 = 1; req_valid_1 = 1;
        n0 = 0; n1 = 0;
        for (int c = 0; c < 20; c++) begin
            cycle_check();
            if (acc_port >= 0) grants.push_back(acc_port);
            if (dut_hs_port == 0) begin chk("contend_p0_result", dut_hs_data, 8'hFE); n0++; end
            if (dut_hs_port == 1) begin chk("contend_p1_result", dut_hs_data, 8'h30); n1++; end
        end
        req_valid_0 = 0; req_valid_1 = 0;
        chk("contend_grant_count", (grants.size() >= 4), 1'b1);
        if (grants.size() >= 4)
            chk("contend_grant_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]},
                {2'd0, 2'd1, 2'd0, 2'd1});
        chk("contend_both_served", (n0 >= 2 && n1 >= 2), 1'b1);

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            req_valid_0 = ($urandom_range(0, 2) != 0);
            req_valid_1 = ($urandom_range(0, 2) != 0);
            req_a_0 = 8'($urandom); req_b_0 = 8'($urandom); req_op_0 = 3'($urandom);
            req_a_1 = 8'($urandom); req_b_1 = 8'($urandom); req_op_1 = 3'($urandom);
            rsp_ready_0 = ($urandom_range(0, 3) != 0);
            rsp_ready_1 = ($urandom_range(0, 3) != 0);
            cycle_check();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
